// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundle of the two requester channels (request and response
//               valid/ready) and the shared-ALU port of alu_arbiter.
//               slave  - the arbiter side
//               master - the requesters plus the ALU side
// Ports       : req{0,1}_valid/ready/a/b/op, resp{0,1}_valid/ready/data/err,
//               alu_a, alu_b, alu_op, alu_out, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int DW  = 32,
  parameter int OPW = 5
);
  logic           req0_valid;
  logic           req0_ready;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic [OPW-1:0] req0_op;
  logic           resp0_valid;
  logic           resp0_ready;
  logic [DW-1:0]  resp0_data;
  logic           resp0_err;

  logic           req1_valid;
  logic           req1_ready;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic [OPW-1:0] req1_op;
  logic           resp1_valid;
  logic           resp1_ready;
  logic [DW-1:0]  resp1_data;
  logic           resp1_err;

  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_out;
  logic           busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, resp1_ready,
    input  alu_out,
    output req0_ready, resp0_valid, resp0_data, resp0_err,
    output req1_ready, resp1_valid, resp1_data, resp1_err,
    output alu_a, alu_b, alu_op, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, resp1_ready,
    output alu_out,
    input  req0_ready, resp0_valid, resp0_data, resp0_err,
    input  req1_ready, resp1_valid, resp1_data, resp1_err,
    input  alu_a, alu_b, alu_op, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               requesters. One operation in flight: IDLE (grant), EXEC
//               (ALU ports driven from registers), RESP (result held until
//               the owner accepts it).
// Ports       : clk - clock, rst - synchronous active-high reset,
//               arb - alu_arbiter_if.slave (request/response channels,
//               ALU operand/opcode/result, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DW     = 32,
  parameter int OPW    = 5,
  parameter int OP_MAX = 6
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  arb
);

  localparam logic [OPW-1:0] c_op_max = OPW'(OP_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_last_grant;
  logic           r_owner;
  logic           r_illegal;
  logic [DW-1:0]  r_alu_a;
  logic [DW-1:0]  r_alu_b;
  logic [OPW-1:0] r_alu_op;
  logic [DW-1:0]  r_data0;
  logic [DW-1:0]  r_data1;
  logic           r_err0;
  logic           r_err1;
  logic           r_rv0;
  logic           r_rv1;

  logic           w_any;
  logic           w_gid;
  logic           w_grant;
  logic           w_hs;
  logic [DW-1:0]  w_a_sel;
  logic [DW-1:0]  w_b_sel;
  logic [OPW-1:0] w_op_sel;
  logic           w_op_illegal;
  logic [DW-1:0]  w_result;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  assign w_any        = arb.req0_valid | arb.req1_valid;
  assign w_gid        = (arb.req0_valid & arb.req1_valid) ? ~r_last_grant : arb.req1_valid;
  assign w_grant      = (r_state == ST_IDLE) & w_any;
  assign w_a_sel      = w_gid ? arb.req1_a  : arb.req0_a;
  assign w_b_sel      = w_gid ? arb.req1_b  : arb.req0_b;
  assign w_op_sel     = w_gid ? arb.req1_op : arb.req0_op;
  assign w_op_illegal = (w_op_sel > c_op_max);
  // An illegal opcode is replaced by NOP on the ALU port, so a zero opcode
  // covers both the NOP and the illegal case here.
  assign w_result     = (r_alu_op == '0) ? '0 : arb.alu_out;
  assign w_hs         = (r_state == ST_RESP) & (r_owner ? arb.resp1_ready : arb.resp0_ready);

  always_comb begin
    w_state_next   = r_state;
    arb.req0_ready = 1'b0;
    arb.req1_ready = 1'b0;
    arb.busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        arb.req0_ready = w_grant & ~w_gid;
        arb.req1_ready = w_grant &  w_gid;
        if (w_any) w_state_next = ST_EXEC;
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (w_hs) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_illegal    <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_data0      <= '0;
      r_data1      <= '0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rv0        <= 1'b0;
      r_rv1        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_alu_a      <= w_a_sel;
            r_alu_b      <= w_b_sel;
            r_alu_op     <= w_op_illegal ? '0 : w_op_sel;
            r_illegal    <= w_op_illegal;
            r_owner      <= w_gid;
            r_last_grant <= w_gid;
          end
        end
        ST_EXEC: begin
          // ALU ports are only meaningful during EXEC.
          r_alu_a  <= '0;
          r_alu_b  <= '0;
          r_alu_op <= '0;
          if (r_owner) begin
            r_data1 <= w_result;
            r_err1  <= r_illegal;
            r_rv1   <= 1'b1;
          end else begin
            r_data0 <= w_result;
            r_err0  <= r_illegal;
            r_rv0   <= 1'b1;
          end
        end
        ST_RESP: begin
          if (w_hs) begin
            r_rv0 <= 1'b0;
            r_rv1 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign arb.alu_a       = r_alu_a;
  assign arb.alu_b       = r_alu_b;
  assign arb.alu_op      = r_alu_op;
  assign arb.resp0_valid = r_rv0;
  assign arb.resp0_data  = r_data0;
  assign arb.resp0_err   = r_err0;
  assign arb.resp1_valid = r_rv1;
  assign arb.resp1_data  = r_data1;
  assign arb.resp1_err   = r_err1;

endmodule
`default_nettype wire
